mac_job_arbiter: RTL and testbench

- Shares one MAC datapath between two requesters.
- Each requester streams a job: a vector of 8-bit operand pairs, last pair flagged.
- The block arbitrates round-robin per job and sequences the datapath for every pair (clear, load, begin_mult, wait end_mult, add).
- It returns the accumulated dot product tagged with the requester id. It sits between the requester logic and the MAC's register/multiplier/accumulator path.

---
 rtl/mac_job_arbiter_if.sv | 52 +++++
 rtl/mac_job_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mac_job_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_job_arbiter_if.sv
// Requester, MAC-datapath and result signals of mac_job_arbiter grouped as one bundle.
// The arbiter connects to the slave modport; its environment uses the master modport.
interface mac_job_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
);
  logic              req0_valid;
  logic              req0_last;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_last;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_ready;
  logic [DATA_W-1:0] mac_op_a;
  logic [DATA_W-1:0] mac_op_b;
  logic              mac_clr;
  logic              mac_load;
  logic              mac_begin_mult;
  logic              mac_end_mult;
  logic              mac_add;
  logic [ACC_W-1:0]  mac_rc;
  logic              res_valid;
  logic              res_ready;
  logic              res_id;
  logic [ACC_W-1:0]  res_data;
  logic              res_err;

  modport slave (
    input  req0_valid, req0_last, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_last, req1_a, req1_b,
    output req1_ready,
    output mac_op_a, mac_op_b, mac_clr, mac_load, mac_begin_mult, mac_add,
    input  mac_end_mult, mac_rc,
    output res_valid, res_id, res_data, res_err,
    input  res_ready
  );

  modport master (
    output req0_valid, req0_last, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_last, req1_a, req1_b,
    input  req1_ready,
    input  mac_op_a, mac_op_b, mac_clr, mac_load, mac_begin_mult, mac_add,
    output mac_end_mult, mac_rc,
    input  res_valid, res_id, res_data, res_err,
    output res_ready
  );
endinterface

// File: rtl/mac_job_arbiter.sv
// Round-robin per-job arbiter sharing one MAC datapath between two requesters;
// sequences clear/load/mult/add per operand pair and returns the tagged dot product.
module mac_job_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_job_arbiter_if.slave bus,
  output logic             busy,
  output logic [2:0]       state
);

  localparam int unsigned BEAT_W = $clog2(MAX_LEN) + 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    MULT  = 3'd3,
    WAIT  = 3'd4,
    ACC   = 3'd5,
    CAPT  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rr_q;
  logic              last_q;
  logic [BEAT_W-1:0] beat_q;
  logic [TO_W-1:0]   to_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [ACC_W-1:0]  res_data_q;
  logic              res_id_q, res_err_q;

  logic start_job, accept, to_clr, to_inc, set_err, capture, release_job;
  logic sel_valid, sel_last;
  logic [DATA_W-1:0] sel_a, sel_b;

  assign sel_valid = grant_q ? bus.req1_valid : bus.req0_valid;
  assign sel_last  = grant_q ? bus.req1_last  : bus.req0_last;
  assign sel_a     = grant_q ? bus.req1_a     : bus.req0_a;
  assign sel_b     = grant_q ? bus.req1_b     : bus.req0_b;

  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    start_job          = 1'b0;
    accept             = 1'b0;
    to_clr             = 1'b0;
    to_inc             = 1'b0;
    set_err            = 1'b0;
    capture            = 1'b0;
    release_job        = 1'b0;
    bus.req0_ready     = 1'b0;
    bus.req1_ready     = 1'b0;
    bus.mac_clr        = 1'b0;
    bus.mac_load       = 1'b0;
    bus.mac_begin_mult = 1'b0;
    bus.mac_add        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // rr pointer wins when valid, otherwise fall back to the other requester
          grant_d     = rr_q ? bus.req1_valid : ~bus.req0_valid;
          start_job   = 1'b1;
          bus.mac_clr = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        bus.req0_ready = ~grant_q;
        bus.req1_ready = grant_q;
        if (sel_valid) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bus.mac_load = 1'b1;
        state_d      = MULT;
      end
      MULT: begin
        bus.mac_begin_mult = 1'b1;
        to_clr             = 1'b1;
        state_d            = WAIT;
      end
      WAIT: begin
        if (bus.mac_end_mult) begin
          state_d = ACC;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          set_err = 1'b1;
          state_d = CAPT;
        end else begin
          to_inc = 1'b1;
        end
      end
      ACC: begin
        bus.mac_add = 1'b1;
        if (last_q) begin
          state_d = CAPT;
        end else if (beat_q == BEAT_W'(MAX_LEN)) begin
          set_err = 1'b1;
          state_d = CAPT;
        end else begin
          state_d = FETCH;
        end
      end
      CAPT: begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          release_job = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      last_q     <= 1'b0;
      beat_q     <= '0;
      to_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (start_job) begin
        beat_q    <= '0;
        res_err_q <= 1'b0;
      end
      if (accept) begin
        op_a_q <= sel_a;
        op_b_q <= sel_b;
        last_q <= sel_last;
        beat_q <= beat_q + 1'b1;
      end
      if (to_clr) begin
        to_q <= '0;
      end else if (to_inc) begin
        to_q <= to_q + 1'b1;
      end
      if (set_err) begin
        res_err_q <= 1'b1;
      end
      if (capture) begin
        res_data_q <= bus.mac_rc;
        res_id_q   <= grant_q;
      end
      if (release_job) begin
        rr_q <= ~grant_q;
      end
    end
  end

  assign bus.mac_op_a  = op_a_q;
  assign bus.mac_op_b  = op_b_q;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_err   = res_err_q;
  assign busy          = (state_q != IDLE);
  assign state         = state_q;

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Directed bench for mac_job_arbiter with a behavioural MAC (end_mult 3 cycles after begin).
module tb_mac_job_arbiter;

  localparam int unsigned MULT_K = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [2:0] state;

  mac_job_arbiter_if #(.DATA_W(8), .ACC_W(20)) bus ();

  mac_job_arbiter #(
    .DATA_W (8),
    .ACC_W  (20),
    .MAX_LEN(16),
    .TIMEOUT(64)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy),
    .state(state)
  );

  always #5 clk = ~clk;

  // behavioural MAC datapath
  logic [19:0] acc = '0;
  logic [7:0]  pa = '0, pb = '0;
  int unsigned mcnt = 0;
  logic        mult_en = 1'b1;

  always @(posedge clk) begin
    if (bus.mac_clr) acc <= '0;
    if (bus.mac_load) begin
      pa <= bus.mac_op_a;
      pb <= bus.mac_op_b;
    end
    if (bus.mac_add) acc <= acc + 20'(pa * pb);
    if (bus.mac_begin_mult) mcnt <= MULT_K;
    else if (mcnt != 0) mcnt <= mcnt - 1;
  end
  assign bus.mac_end_mult = mult_en && (mcnt == 1);
  assign bus.mac_rc       = acc;

  int clr_cnt = 0, load_cnt = 0, begin_cnt = 0, add_cnt = 0, wait_cnt = 0, overlap_cnt = 0;
  always @(posedge clk) begin
    if (bus.mac_clr) clr_cnt++;
    if (bus.mac_load) load_cnt++;
    if (bus.mac_begin_mult) begin_cnt++;
    if (bus.mac_add) add_cnt++;
    if (state == 3'd4) wait_cnt++;
    if (32'(bus.mac_clr) + 32'(bus.mac_load) + 32'(bus.mac_begin_mult) + 32'(bus.mac_add) > 1)
      overlap_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    clr_cnt = 0; load_cnt = 0; begin_cnt = 0; add_cnt = 0; wait_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input bit id, input logic [7:0] a, input logic [7:0] b, input bit last);
    int n = 0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_last = last;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_last = last;
    end
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic get_res(input bit id, input logic [19:0] data, input bit err, input int hold);
    int n = 0;
    bit stable = 1'b1;
    while (!bus.res_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("res_timeout", 32'(n), 32'd0);
    check("res_id", 32'(bus.res_id), 32'(id));
    check("res_data", 32'(bus.res_data), 32'(data));
    check("res_err", 32'(bus.res_err), 32'(err));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!bus.res_valid || bus.res_data !== data || bus.res_id !== id ||
            bus.req0_ready || bus.req1_ready || state !== 3'd7) stable = 1'b0;
      end
      check("done_stable", 32'(stable), 32'd1);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_valid_drop", 32'(bus.res_valid), 32'd0);
    check("idle_after_done", 32'(state), 32'd0);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_last = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_last = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.res_ready = 1'b0;

    // reset state
    do_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_readies", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);

    // single job from req0: 3*4 + 5*6 = 42
    clear_counts();
    fork
      begin send(1'b0, 8'd3, 8'd4, 1'b0); send(1'b0, 8'd5, 8'd6, 1'b1); end
      get_res(1'b0, 20'd42, 1'b0, 0);
    join
    check("t1_clr", 32'(clr_cnt), 32'd1);
    check("t1_load", 32'(load_cnt), 32'd2);
    check("t1_begin", 32'(begin_cnt), 32'd2);
    check("t1_add", 32'(add_cnt), 32'd2);

    // both valid after reset: req0 first, then req1; next tie goes back to req0
    do_reset();
    fork
      send(1'b0, 8'd1, 8'd2, 1'b1);
      send(1'b1, 8'd2, 8'd2, 1'b1);
      begin get_res(1'b0, 20'd2, 1'b0, 0); get_res(1'b1, 20'd4, 1'b0, 0); end
    join
    fork
      send(1'b0, 8'd1, 8'd1, 1'b1);
      send(1'b1, 8'd7, 8'd7, 1'b1);
      begin get_res(1'b0, 20'd1, 1'b0, 0); get_res(1'b1, 20'd49, 1'b0, 0); end
    join

    // multiplier never finishes: timeout after 64 WAIT cycles, no add
    mult_en = 1'b0;
    clear_counts();
    fork
      send(1'b0, 8'd9, 8'd9, 1'b1);
      get_res(1'b0, 20'd0, 1'b1, 0);
    join
    check("t3_add", 32'(add_cnt), 32'd0);
    check("t3_wait_cycles", 32'(wait_cnt), 32'd64);
    mult_en = 1'b1;
    repeat (MULT_K + 1) @(negedge clk);

    // length overrun: 16 beats of 255*255 without last, 17th beat opens a new job
    clear_counts();
    fork
      begin
        for (int i = 0; i < 17; i++) send(1'b0, 8'd255, 8'd255, 1'b0);
        send(1'b0, 8'd255, 8'd255, 1'b1);
      end
      begin
        get_res(1'b0, 20'd1040400, 1'b1, 0);
        get_res(1'b0, 20'd130050, 1'b0, 0);
      end
    join
    check("t4_add", 32'(add_cnt), 32'd18);
    check("t4_clr", 32'(clr_cnt), 32'd2);

    // consumer stalls 10 cycles in DONE
    fork
      send(1'b1, 8'd6, 8'd7, 1'b1);
      get_res(1'b1, 20'd42, 1'b0, 10);
    join

    // reset in the middle of a 3-pair job
    begin
      int n = 0;
      bit quiet = 1'b1;
      send(1'b0, 8'd1, 8'd2, 1'b0);
      while (state !== 3'd4 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("t6_reach_wait", 32'(state), 32'd4);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_state", 32'(state), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_pulses", {28'd0, bus.mac_clr, bus.mac_load, bus.mac_begin_mult, bus.mac_add}, 32'd0);
      check("t6_res_valid", 32'(bus.res_valid), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus.res_valid || busy) quiet = 1'b0;
      end
      check("t6_no_result", 32'(quiet), 32'd1);
      fork
        begin send(1'b1, 8'd10, 8'd10, 1'b0); send(1'b1, 8'd2, 8'd3, 1'b1); end
        get_res(1'b1, 20'd106, 1'b0, 0);
      join
    end

    check("pulse_overlap", 32'(overlap_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
